// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// One pipeline stage register with valid/allowin handshaking, synchronous
// flush, and a saturating stall counter. The payload is an opaque bundle of
// packed control fields.
//
// Optional feature (compile-time macro PIPE_STAGE_SKID_EN):
//   Adds a 1-entry skid buffer behind the main entry. in_allowin is then a
//   pure register output (!skid_valid), which breaks the combinational
//   allowin chain from downstream.
//
// Parameters:
//   DATA_W     payload width in bits (1..256)
//   RESET_VAL  payload register value after reset
//
// Ports:
//   clk          clock, rising edge
//   rsta         asynchronous active-high reset
//   in_valid     upstream holds a valid instruction
//   in_data      upstream payload
//   in_allowin   this stage accepts upstream data this cycle
//   ready_go     the held instruction has finished its work in this stage
//   out_allowin  downstream accepts data
//   out_valid    valid && ready_go, offered downstream
//   out_data     registered payload of the main entry
//   flush        synchronous kill of all held contents
//   stall_cnt    saturating count of cycles a valid item failed to advance
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rsta,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_allowin,
    input  logic              ready_go,
    input  logic              out_allowin,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [15:0]       stall_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       stall_q, stall_d;
    logic              advance;

    assign advance   = valid_q & ready_go & out_allowin;
    assign out_valid = valid_q & ready_go;
    assign out_data  = data_q;
    assign stall_cnt = stall_q;

    // Stall: a valid item that does not leave this cycle. Flush is not a stall.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !advance && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              accept;

    // Registered allowin: only a full skid entry can refuse input.
    assign in_allowin = ~skid_valid_q;
    assign accept     = in_valid & in_allowin;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (advance) begin
            if (skid_valid_q) begin
                // Skid drains into main; accept is 0 here since in_allowin is 0.
                valid_d      = 1'b1;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = accept;
                if (accept) begin
                    data_d = in_data;
                end
            end
        end else if (!valid_q) begin
            valid_d = accept;
            if (accept) begin
                data_d = in_data;
            end
        end else if (accept) begin
            // Main is occupied and not leaving: park the new item behind it.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VAL;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`else

    // Stage is free if empty, or if its item leaves this same cycle.
    assign in_allowin = ~valid_q | (ready_go & out_allowin);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_allowin) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

`endif

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
            stall_q <= 16'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Bench for pipe_stage_reg. The reference model treats the stage as a small
// FIFO of held items (capacity 1, or 2 with PIPE_STAGE_SKID_EN) plus the
// payload most recently presented at the head, and a saturating stall count.
// Inputs change 1 ns after the rising edge; the compare process samples on
// the falling edge and then advances the model by one clock.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_stage_reg;

    localparam int unsigned       DW   = 16;
    localparam logic [DW-1:0]     RVAL = 16'hBEEF;

    logic          clk;
    logic          rsta;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_allowin;
    logic          ready_go;
    logic          out_allowin;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [15:0]   stall_cnt;

    int checks;
    int failures;

    pipe_stage_reg #(
        .DATA_W   (DW),
        .RESET_VAL(RVAL)
    ) dut (
        .clk        (clk),
        .rsta       (rsta),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_allowin (in_allowin),
        .ready_go   (ready_go),
        .out_allowin(out_allowin),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .flush      (flush),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_head;
    int            m_stall;

    always @(negedge clk) begin : model
        logic adv;
        logic acc;
        logic exp_allow;
        if (rsta) begin
            q.delete();
            last_head = RVAL;
            m_stall   = 0;
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            exp_allow = (q.size() < 2);
`else
            exp_allow = (q.size() == 0) || (ready_go && out_allowin);
`endif
            check("in_allowin", 64'(in_allowin), 64'(exp_allow));
            check("out_valid", 64'(out_valid), 64'((q.size() > 0) && ready_go));
            check("out_data", 64'(out_data), 64'(last_head));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));

            adv = (q.size() > 0) && ready_go && out_allowin;
            acc = in_valid && exp_allow && !flush;
            if ((q.size() > 0) && !adv && !flush && (m_stall < 65535)) begin
                m_stall++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (adv) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
            if (q.size() > 0) last_head = q[0];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic rg,
                         input logic oa, input logic fl);
        @(posedge clk);
        #1;
        in_valid    = iv;
        in_data     = d;
        ready_go    = rg;
        out_allowin = oa;
        flush       = fl;
        #2;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        checks      = 0;
        failures    = 0;
        rsta        = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        ready_go    = 1'b0;
        out_allowin = 1'b0;
        flush       = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(RVAL));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_allowin", 64'(in_allowin), 64'(1));
        rsta = 1'b0;

        // Streaming, 1 item per cycle.
        drive(1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
        check("stream_v0", 64'(out_valid), 64'(0));
        drive(1'b1, 16'h0002, 1'b1, 1'b1, 1'b0);
        check("stream_d1", 64'(out_data), 64'(16'h0001));
        check("stream_v1", 64'(out_valid), 64'(1));
        drive(1'b1, 16'h0003, 1'b1, 1'b1, 1'b0);
        check("stream_d2", 64'(out_data), 64'(16'h0002));
        check("stream_v2", 64'(out_valid), 64'(1));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("stream_d3", 64'(out_data), 64'(16'h0003));
        check("stream_v3", 64'(out_valid), 64'(1));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("stream_empty", 64'(out_valid), 64'(0));
        check("stream_stall", 64'(stall_cnt), 64'(0));

        // Backpressure for 5 cycles.
        drive(1'b1, 16'h00AA, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            check("bp_data", 64'(out_data), 64'(16'h00AA));
            check("bp_valid", 64'(out_valid), 64'(1));
`ifndef PIPE_STAGE_SKID_EN
            check("bp_allowin", 64'(in_allowin), 64'(0));
`endif
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("bp_stall5", 64'(stall_cnt), 64'(5));
        check("bp_release_v", 64'(out_valid), 64'(1));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("bp_once", 64'(out_valid), 64'(0));
        check("bp_stall_hold", 64'(stall_cnt), 64'(5));

        // Flush beats a concurrent load.
        drive(1'b1, 16'h0055, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h0066, 1'b1, 1'b1, 1'b1);
        check("fl_pre_d", 64'(out_data), 64'(16'h0055));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("fl_valid", 64'(out_valid), 64'(0));
        check("fl_no_cap", 64'(out_data), 64'(16'h0055));
        check("fl_stall", 64'(stall_cnt), 64'(5));

        // ready_go low for 3 cycles.
        drive(1'b1, 16'h0077, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
            check("rg_valid", 64'(out_valid), 64'(0));
            check("rg_data", 64'(out_data), 64'(16'h0077));
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("rg_go", 64'(out_valid), 64'(1));
        check("rg_stall8", 64'(stall_cnt), 64'(8));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("rg_gone", 64'(out_valid), 64'(0));

`ifdef PIPE_STAGE_SKID_EN
        // Two items into a blocked stage: second lands in skid.
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        check("sk_allow0", 64'(in_allowin), 64'(1));
        drive(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        check("sk_allow1", 64'(in_allowin), 64'(1));
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("sk_full", 64'(in_allowin), 64'(0));
        check("sk_head", 64'(out_data), 64'(16'h0001));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("sk_out1", 64'(out_data), 64'(16'h0001));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("sk_out2", 64'(out_data), 64'(16'h0002));
        check("sk_out2_v", 64'(out_valid), 64'(1));
        check("sk_drained", 64'(in_allowin), 64'(1));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("sk_empty", 64'(out_valid), 64'(0));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom % 2), DW'($urandom), 1'(($urandom % 4) != 0),
                  1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0));
        end

        // Saturation, then asynchronous reset mid-stall.
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 16'h0099, 1'b1, 1'b1, 1'b0);
        repeat (70000) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("sat_stall", 64'(stall_cnt), 64'(16'hFFFF));
        check("sat_data", 64'(out_data), 64'(16'h0099));
        rsta = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_data", 64'(out_data), 64'(RVAL));
        check("arst_stall", 64'(stall_cnt), 64'(0));
        check("arst_allowin", 64'(in_allowin), 64'(1));
        drive(1'b1, 16'h0005, 1'b1, 1'b1, 1'b0);
        check("rst_hold_valid", 64'(out_valid), 64'(0));
        check("rst_hold_data", 64'(out_data), 64'(RVAL));
        check("rst_hold_allow", 64'(in_allowin), 64'(1));
        rsta = 1'b0;
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("resume_data", 64'(out_data), 64'(16'h0005));
        check("resume_valid", 64'(out_valid), 64'(1));
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
